// File: rtl/multilane_deserializer.sv
// Multi-lane serial-to-parallel receiver: gathers LANES bits per enabled beat into a
// WIDTH-bit word and hands completed words off via a valid/ready holding register.
module multilane_deserializer #(
    parameter int WIDTH     = 64,
    parameter int LANES     = 1,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [LANES-1:0] sampled_bits,
    input  logic             deser_en,
    input  logic             deser_clr,
    input  logic             data_ready,
    output logic [WIDTH-1:0] P_DATA,
    output logic             data_valid,
    output logic             overflow
);

    localparam int BEATS = WIDTH / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [IW-1:0] TOP_BIT   = IW'(WIDTH - 1);

    generate
        if (WIDTH % LANES != 0) begin : g_bad_width
            $error("multilane_deserializer: WIDTH must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     beat_cnt;
    logic [WIDTH-1:0]  shift_reg;
    logic [WIDTH-1:0]  merged;
    logic [IW-1:0]     bit_idx;
    logic              complete;
    logic              load;
    logic              drop;

    // A cleared edge never counts as a beat, so it can never complete a word.
    assign complete = deser_en && !deser_clr && (beat_cnt == LAST_BEAT);

    // Partial word plus the current beat placed at its final bit positions; the
    // register is zeroed at every word boundary so an overwrite equals a merge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        merged  = shift_reg;
        bit_idx = '0;
        for (int l = 0; l < LANES; l++) begin
            bit_idx = IW'(int'(beat_cnt) * LANES + l);
            if (LSB_FIRST)
                merged[bit_idx] = sampled_bits[l];
            else
                merged[TOP_BIT - bit_idx] = sampled_bits[l];
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous and active-low; it is just the highest-priority branch.
        if (!RST || deser_clr) begin
            beat_cnt  <= '0;
            shift_reg <= '0;
        end else if (deser_en) begin
            if (beat_cnt == LAST_BEAT) begin
                beat_cnt  <= '0;
                shift_reg <= '0;
            end else begin
                beat_cnt  <= beat_cnt + 1'b1;
                shift_reg <= merged;
            end
        end
    end

    // Output FSM: the state is data_valid itself.
    always_ff @(posedge CLK) begin
        if (!RST)
            state <= EMPTY;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            EMPTY: begin
                if (complete) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (complete && data_ready)
                    load = 1'b1;
                else if (complete)
                    drop = 1'b1;
                else if (data_ready)
                    state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        data_valid = (state == FULL);
    end

    // Holding register keeps its last word after consumption; overflow is sticky.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            P_DATA   <= '0;
            overflow <= 1'b0;
        end else begin
            if (load)
                P_DATA <= merged;
            if (deser_clr)
                overflow <= 1'b0;
            else if (drop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multilane_deserializer.sv
// Directed bench: 64x1 LSB-first instance plus 16x4 LSB-first and MSB-first instances.
module tb_multilane_deserializer;

    logic        clk;
    logic        rst;

    logic [0:0]  bits64;
    logic        en64, clr64, rdy64;
    logic [63:0] pd64;
    logic        v64, o64;

    logic [3:0]  bits16;
    logic        en16, clr16, rdy16;
    logic [15:0] pdl, pdm;
    logic        vl, vm, ol, om;

    int n_checks = 0;
    int n_err    = 0;

    multilane_deserializer #(.WIDTH(64), .LANES(1), .LSB_FIRST(1'b1)) u_d64 (
        .CLK(clk), .RST(rst), .sampled_bits(bits64), .deser_en(en64), .deser_clr(clr64),
        .data_ready(rdy64), .P_DATA(pd64), .data_valid(v64), .overflow(o64)
    );

    multilane_deserializer #(.WIDTH(16), .LANES(4), .LSB_FIRST(1'b1)) u_d16l (
        .CLK(clk), .RST(rst), .sampled_bits(bits16), .deser_en(en16), .deser_clr(clr16),
        .data_ready(rdy16), .P_DATA(pdl), .data_valid(vl), .overflow(ol)
    );

    multilane_deserializer #(.WIDTH(16), .LANES(4), .LSB_FIRST(1'b0)) u_d16m (
        .CLK(clk), .RST(rst), .sampled_bits(bits16), .deser_en(en16), .deser_clr(clr16),
        .data_ready(rdy16), .P_DATA(pdm), .data_valid(vm), .overflow(om)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  bits;
        logic        en;
        logic        clr;
        logic        rdy;
        logic        exp_valid;
        logic [15:0] exp_l;
        logic [15:0] exp_m;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(input logic [3:0] b, input logic e, input logic c,
                                input logic r, input logic ev, input logic [15:0] l,
                                input logic [15:0] m, input logic eo);
        vec_t t;
        t.bits = b; t.en = e; t.clr = c; t.rdy = r;
        t.exp_valid = ev; t.exp_l = l; t.exp_m = m; t.exp_ovf = eo;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 64-bit word LSB first; optional idle beat (with inverted junk bits) between beats.
    task automatic send64(input logic [63:0] w, input bit gaps, output int early_valid);
        early_valid = 0;
        for (int i = 0; i < 64; i++) begin
            if (gaps && i > 0) begin
                en64   = 1'b0;
                bits64 = ~w[i];
                tick();
                if (v64) early_valid++;
            end
            en64   = 1'b1;
            bits64 = w[i];
            tick();
            if (i < 63 && v64) early_valid++;
        end
        en64 = 1'b0;
    endtask

    initial begin
        int ev;

        //            bits  en    clr   rdy   valid l        m        ovf
        vecs[0]  = mk(4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        vecs[1]  = mk(4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        vecs[2]  = mk(4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        vecs[3]  = mk(4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4321, 16'h84C2, 1'b0);
        vecs[4]  = mk(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4321, 16'h84C2, 1'b0);
        vecs[5]  = mk(4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4321, 16'h84C2, 1'b0);
        vecs[6]  = mk(4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4321, 16'h84C2, 1'b0);
        vecs[7]  = mk(4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4321, 16'h84C2, 1'b0);
        vecs[8]  = mk(4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h2C48, 1'b0);
        vecs[9]  = mk(4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h2C48, 1'b0);
        vecs[10] = mk(4'hD, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h2C48, 1'b0);
        vecs[11] = mk(4'hC, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h2C48, 1'b0);
        vecs[12] = mk(4'hB, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h2C48, 1'b0);
        vecs[13] = mk(4'hA, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h2C48, 1'b1);
        vecs[14] = mk(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h2C48, 1'b1);
        vecs[15] = mk(4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h2C48, 1'b0);
        vecs[16] = mk(4'hD, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h2C48, 1'b0);
        vecs[17] = mk(4'hC, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h2C48, 1'b0);
        vecs[18] = mk(4'hB, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h2C48, 1'b0);
        vecs[19] = mk(4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 16'hABCD, 16'hB3D5, 1'b0);
        vecs[20] = mk(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hABCD, 16'hB3D5, 1'b0);
        vecs[21] = mk(4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 16'hABCD, 16'hB3D5, 1'b0);
        vecs[22] = mk(4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hABCD, 16'hB3D5, 1'b0);
        vecs[23] = mk(4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hABCD, 16'hB3D5, 1'b0);
        vecs[24] = mk(4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 16'hABCD, 16'hB3D5, 1'b0);
        vecs[25] = mk(4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 16'hABCD, 16'hB3D5, 1'b0);
        vecs[26] = mk(4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4321, 16'h84C2, 1'b0);
        vecs[27] = mk(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4321, 16'h84C2, 1'b0);

        rst = 1'b0;
        bits64 = '0; en64 = 1'b0; clr64 = 1'b0; rdy64 = 1'b0;
        bits16 = '0; en16 = 1'b0; clr16 = 1'b0; rdy16 = 1'b0;
        tick();
        tick();
        check("reset_d64_data",  pd64, 64'h0);
        check("reset_d64_valid", {63'h0, v64}, 64'h0);
        check("reset_d64_ovf",   {63'h0, o64}, 64'h0);
        check("reset_d16_data",  {32'h0, pdl, pdm}, 64'h0);
        check("reset_d16_flags", {60'h0, vl, vm, ol, om}, 64'h0);
        rst = 1'b1;

        // 16-bit instances: mapping, overflow, no-bubble hand-off, clear.
        for (int i = 0; i < 28; i++) begin
            bits16 = vecs[i].bits;
            en16   = vecs[i].en;
            clr16  = vecs[i].clr;
            rdy16  = vecs[i].rdy;
            tick();
            check($sformatf("v%0d_lsb_valid", i), {63'h0, vl}, {63'h0, vecs[i].exp_valid});
            check($sformatf("v%0d_lsb_data", i),  {48'h0, pdl}, {48'h0, vecs[i].exp_l});
            check($sformatf("v%0d_lsb_ovf", i),   {63'h0, ol}, {63'h0, vecs[i].exp_ovf});
            check($sformatf("v%0d_msb_valid", i), {63'h0, vm}, {63'h0, vecs[i].exp_valid});
            check($sformatf("v%0d_msb_data", i),  {48'h0, pdm}, {48'h0, vecs[i].exp_m});
            check($sformatf("v%0d_msb_ovf", i),   {63'h0, om}, {63'h0, vecs[i].exp_ovf});
        end
        en16 = 1'b0; clr16 = 1'b0;

        // 64x1: single word with consumer always ready.
        rdy64 = 1'b1;
        send64(64'hDEADBEEF_01234567, 1'b0, ev);
        check("t1_no_early_valid", 64'(ev), 64'h0);
        check("t1_valid", {63'h0, v64}, 64'h1);
        check("t1_data",  pd64, 64'hDEADBEEF_01234567);
        tick();
        check("t1_valid_one_cycle", {63'h0, v64}, 64'h0);
        check("t1_data_held", pd64, 64'hDEADBEEF_01234567);

        // Overflow on 64x1, then clear mid-word and resume with enable gaps.
        rdy64 = 1'b0;
        send64(64'h01234567_89ABCDEF, 1'b0, ev);
        check("t5_first_valid", {63'h0, v64}, 64'h1);
        send64(64'hFFFF0000_FFFF0000, 1'b0, ev);
        check("t5_ovf_set",   {63'h0, o64}, 64'h1);
        check("t5_data_kept", pd64, 64'h01234567_89ABCDEF);
        rdy64 = 1'b1;
        tick();
        check("t5_consumed", {63'h0, v64}, 64'h0);
        rdy64 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            en64 = 1'b1; bits64 = 1'b1;
            tick();
        end
        clr64 = 1'b1; en64 = 1'b1; bits64 = 1'b1;
        tick();
        clr64 = 1'b0; en64 = 1'b0;
        check("t5_ovf_cleared", {63'h0, o64}, 64'h0);
        check("t5_clr_no_valid", {63'h0, v64}, 64'h0);
        send64(64'hCAFEF00D_5555AAAA, 1'b1, ev);
        check("t5_gap_valid", {63'h0, v64}, 64'h1);
        check("t5_gap_data",  pd64, 64'hCAFEF00D_5555AAAA);
        check("t5_gap_ovf",   {63'h0, o64}, 64'h0);

        // Reset mid-word with a word still pending; reset also wins over an enabled beat.
        for (int i = 0; i < 20; i++) begin
            en64 = 1'b1; bits64 = 1'(i);
            tick();
        end
        rst = 1'b0; en64 = 1'b1; bits64 = 1'b1;
        tick();
        rst = 1'b1; en64 = 1'b0;
        check("t6_rst_data",  pd64, 64'h0);
        check("t6_rst_valid", {63'h0, v64}, 64'h0);
        check("t6_rst_ovf",   {63'h0, o64}, 64'h0);
        rdy64 = 1'b1;
        send64(64'h0F1E2D3C_4B5A6978, 1'b0, ev);
        check("t6_post_valid", {63'h0, v64}, 64'h1);
        check("t6_post_data",  pd64, 64'h0F1E2D3C_4B5A6978);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
